ccd_fifo_read_arbiter: RTL and testbench

Read-side scheduler for the bank of NUM_FIFO convolution-data FIFOs that the write-side generator fills round-robin. It watches every FIFO's empty flag, issues one-hot read enables, and merges the returned words into a single valid/ready stream tagged with the source FIFO index. The merged stream feeds the convolution datapath. A two-entry output buffer with in-flight credit accounting sustains one word per cycle under back-pressure.

---
 rtl/ccd_fifo_read_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_ccd_fifo_read_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccd_fifo_read_arbiter.sv
// rtl/ccd_fifo_read_arbiter.sv - round-robin read scheduler merging NUM_FIFO FIFOs into one stream
//
// Purpose:
//   Watches the per-FIFO empty flags, issues at most one read enable per
//   cycle and merges the returned words into a single valid/ready stream.
//   Each word is tagged with the index of the FIFO it came from. A two-entry
//   output buffer with in-flight credit accounting keeps one word per cycle
//   flowing under back-pressure without ever overflowing.
//
// Ports:
//   rd_clk_i      single clock
//   rd_rst_i      synchronous active-high reset
//   arb_en_i      enables issuing new reads
//   skip_empty_i  1: grant first non-empty FIFO from ptr; 0: strict round-robin
//   empty_i       per-FIFO empty flags
//   rd_en_o       per-FIFO read enables (one-hot or all zero, combinational)
//   rd_data_i     per-FIFO read data, valid the cycle after rd_en_o
//   out_valid_o   head word available
//   out_ready_i   consumer accepts the head word
//   out_data_o    head word data
//   out_src_o     FIFO index of the head word
//   busy_o        block is not idle

module ccd_fifo_read_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_FIFO   = 16,
  localparam int IW        = $clog2(NUM_FIFO)
) (
  input  logic                  rd_clk_i,
  input  logic                  rd_rst_i,
  input  logic                  arb_en_i,
  input  logic                  skip_empty_i,
  input  logic                  empty_i   [NUM_FIFO],
  output logic                  rd_en_o   [NUM_FIFO],
  input  logic [DATA_WIDTH-1:0] rd_data_i [NUM_FIFO],
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [IW-1:0]         out_src_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic                  infl_q, infl_d;
  logic [IW-1:0]         infl_idx_q, infl_idx_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] head_data_q, head_data_d;
  logic [IW-1:0]         head_src_q, head_src_d;
  logic [DATA_WIDTH-1:0] tail_data_q, tail_data_d;
  logic [IW-1:0]         tail_src_q, tail_src_d;

  logic                  grant_found;
  logic [IW-1:0]         grant_idx;
  logic [2:0]            occ;
  logic                  pop;
  logic                  issue;
  logic                  cap;
  logic [DATA_WIDTH-1:0] cap_data;

  // Grant search. In skip mode the first non-empty FIFO at or after ptr
  // wins; otherwise only FIFO ptr may be granted.
  always_comb begin : grant_search
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = ptr_q;
    if (skip_empty_i) begin
      for (int i = 0; i < NUM_FIFO; i++) begin
        idx = int'(ptr_q) + i;
        if (idx >= NUM_FIFO) idx = idx - NUM_FIFO;
        if (!grant_found && !empty_i[idx]) begin
          grant_found = 1'b1;
          grant_idx   = IW'(idx);
        end
      end
    end else begin
      grant_found = !empty_i[ptr_q];
    end
  end

  // Credit: buffered words plus the word in flight must leave room for the
  // word a new issue will return, after accounting for this cycle's pop.
  assign occ   = {1'b0, cnt_q} + {2'b00, infl_q};
  assign pop   = out_valid_o && out_ready_i;
  assign issue = (state_q == ST_RUN) && !rd_rst_i && grant_found &&
                 ((occ - {2'b00, pop}) < 3'd2);

  always_comb begin
    for (int k = 0; k < NUM_FIFO; k++) begin
      rd_en_o[k] = issue && (grant_idx == IW'(k));
    end
  end

  assign cap      = infl_q;
  assign cap_data = rd_data_i[infl_idx_q];

  always_comb begin
    ptr_d      = ptr_q;
    infl_d     = issue;
    infl_idx_d = infl_idx_q;
    if (issue) begin
      infl_idx_d = grant_idx;
      ptr_d      = (grant_idx == IW'(NUM_FIFO - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Two-entry buffer: head feeds the output, tail holds the second word.
  // A capture with a simultaneous pop lands the new word behind whatever
  // remains, so order is preserved and the count is unchanged.
  always_comb begin
    cnt_d       = cnt_q;
    head_data_d = head_data_q;
    head_src_d  = head_src_q;
    tail_data_d = tail_data_q;
    tail_src_d  = tail_src_q;
    case ({cap, pop})
      2'b10: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd0) begin
          head_data_d = cap_data;
          head_src_d  = infl_idx_q;
        end else begin
          tail_data_d = cap_data;
          tail_src_d  = infl_idx_q;
        end
      end
      2'b01: begin
        cnt_d       = cnt_q - 2'd1;
        head_data_d = tail_data_q;
        head_src_d  = tail_src_q;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_data_d = cap_data;
          head_src_d  = infl_idx_q;
        end else begin
          head_data_d = tail_data_q;
          head_src_d  = tail_src_q;
          tail_data_d = cap_data;
          tail_src_d  = infl_idx_q;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (arb_en_i) state_d = ST_RUN;
      ST_RUN:   if (!arb_en_i) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (arb_en_i)         state_d = ST_RUN;
        else if (occ == 3'd0) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge rd_clk_i) begin
    if (rd_rst_i) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      infl_q      <= 1'b0;
      infl_idx_q  <= '0;
      cnt_q       <= 2'd0;
      head_data_q <= '0;
      head_src_q  <= '0;
      tail_data_q <= '0;
      tail_src_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      infl_q      <= infl_d;
      infl_idx_q  <= infl_idx_d;
      cnt_q       <= cnt_d;
      head_data_q <= head_data_d;
      head_src_q  <= head_src_d;
      tail_data_q <= tail_data_d;
      tail_src_q  <= tail_src_d;
    end
  end

  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = head_data_q;
  assign out_src_o   = head_src_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ccd_fifo_read_arbiter.sv
// tb/tb_ccd_fifo_read_arbiter.sv - directed scoreboard bench for ccd_fifo_read_arbiter

module tb_ccd_fifo_read_arbiter;
  localparam int DW = 16;
  localparam int NF = 16;
  localparam int IW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, arb_en, skip, out_ready, out_valid, busy;
  logic          empty   [NF];
  logic          rd_en   [NF];
  logic [DW-1:0] rd_data [NF] = '{default: '0};
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_src;

  int checks = 0;
  int errors = 0;
  int n_push = 0;
  int n_pop  = 0;

  ccd_fifo_read_arbiter #(.DATA_WIDTH(DW), .NUM_FIFO(NF)) dut (
    .rd_clk_i    (clk),
    .rd_rst_i    (rst),
    .arb_en_i    (arb_en),
    .skip_empty_i(skip),
    .empty_i     (empty),
    .rd_en_o     (rd_en),
    .rd_data_i   (rd_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_src_o   (out_src),
    .busy_o      (busy)
  );

  logic [NF-1:0] rd_vec;
  always_comb begin
    rd_vec = '0;
    for (int k = 0; k < NF; k++) rd_vec[k] = rd_en[k];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // FIFO models: each read returns a word carrying the FIFO index and a
  // per-FIFO sequence number, one cycle after rd_en.
  bit          fixed_data = 1'b0;
  logic [11:0] rcnt [NF] = '{default: '0};

  function automatic logic [DW-1:0] word_of(input int k, input logic [11:0] c, input bit fx);
    logic [3:0] kk;
    kk = 4'(k);
    return fx ? (16'h0A00 | {12'h000, kk}) : {kk, c};
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < NF; k++) begin
      if (rd_en[k]) begin
        rd_data[k] <= word_of(k, rcnt[k], fixed_data);
        rcnt[k]    <= rcnt[k] + 12'd1;
      end
    end
  end

  // Scoreboard: expected word pushed when a read is driven, compared on pop.
  logic [IW+DW-1:0] sb [$];

  always @(negedge clk) begin
    logic [IW+DW-1:0] exp_w;
    chk("rd_en_onehot0", 32'($onehot0(rd_vec)), 32'd1);
    if (out_valid && out_ready) begin
      exp_w = 'x;
      if (sb.size() > 0) exp_w = sb.pop_front();
      chk("sb_word", 32'({out_src, out_data}), 32'(exp_w));
      n_pop++;
    end
    for (int k = 0; k < NF; k++) begin
      if (rd_en[k]) begin
        sb.push_back({IW'(k), word_of(k, rcnt[k], fixed_data)});
        n_push++;
      end
    end
  end

  task automatic drive_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive_cycle();
    rst = 1'b1; arb_en = 1'b0; out_ready = 1'b0;
    drive_cycle();
    sb.delete();
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    drive_cycle();
    arb_en = 1'b0; out_ready = 1'b1;
    n = 0;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", 32'(busy), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int exp_g [4];
    exp_g = '{3, 9, 3, 9};
    rst = 1'b1; arb_en = 1'b0; skip = 1'b1; out_ready = 1'b0;
    for (int k = 0; k < NF; k++) empty[k] = 1'b0;

    // reset state
    drive_cycle();
    sample();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_src", 32'(out_src), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_en", 32'(rd_vec), 32'd0);

    // full-rate round-robin walk
    drive_cycle();
    rst = 1'b0; out_ready = 1'b1;
    drive_cycle();
    arb_en = 1'b1;
    sample();
    chk("t1_c0_rd_en", 32'(rd_vec), 32'd0);
    chk("t1_c0_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i <= 16; i++) begin
      sample();
      chk("t1_rd_en", 32'(rd_vec), 32'h1 << (i % 16));
      chk("t1_busy", 32'(busy), 32'd1);
      chk("t1_valid", 32'(out_valid), 32'(i >= 2));
      if (i >= 2) chk("t1_src", 32'(out_src), 32'((i - 2) % 16));
    end
    wait_idle();
    do_reset();

    // skip mode, only FIFOs 3 and 9 non-empty
    fixed_data = 1'b1;
    for (int k = 0; k < NF; k++) empty[k] = !(k == 3 || k == 9);
    skip = 1'b1; out_ready = 1'b1;
    drive_cycle();
    arb_en = 1'b1;
    sample();
    chk("t2_c0_rd_en", 32'(rd_vec), 32'd0);
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("t2_grant", 32'(rd_vec), 32'h1 << exp_g[i]);
      if (i == 2) chk("t2_ptr", 32'(dut.ptr_q), 32'd10);
      if (i >= 2) begin
        chk("t2_data", 32'(out_data), (exp_g[i-2] == 3) ? 32'h0A03 : 32'h0A09);
        chk("t2_src", 32'(out_src), 32'(exp_g[i-2]));
      end
    end
    wait_idle();
    fixed_data = 1'b0;
    do_reset();
    for (int k = 0; k < NF; k++) empty[k] = 1'b0;

    // strict round-robin stalls on an empty FIFO at ptr
    skip = 1'b0; out_ready = 1'b1;
    drive_cycle();
    arb_en = 1'b1;
    sample();
    chk("t3_c0_rd_en", 32'(rd_vec), 32'd0);
    sample();
    chk("t3_grant0", 32'(rd_vec), 32'h1);
    drive_cycle();
    empty[2] = 1'b1;
    sample();
    chk("t3_grant1", 32'(rd_vec), 32'h2);
    for (int i = 0; i < 5; i++) begin
      sample();
      chk("t3_stall", 32'(rd_vec), 32'd0);
    end
    drive_cycle();
    empty[2] = 1'b0;
    sample();
    chk("t3_grant2", 32'(rd_vec), 32'h4);
    sample();
    chk("t3_grant3", 32'(rd_vec), 32'h8);
    wait_idle();
    do_reset();

    // back-pressure: two issues only, head held stable
    skip = 1'b1;
    drive_cycle();
    arb_en = 1'b1;
    pulses = 0;
    for (int i = 0; i <= 10; i++) begin
      sample();
      pulses += $countones(rd_vec);
      if (i >= 3) chk("t4_head", 32'({out_src, out_data}), 32'(sb[0]));
    end
    chk("t4_pulses", 32'(pulses), 32'd2);
    chk("t4_valid", 32'(out_valid), 32'd1);
    chk("t4_src", 32'(out_src), 32'd0);
    wait_idle();
    chk("t4_no_loss", 32'(n_pop), 32'(n_push));
    do_reset();

    // drain with words buffered and in flight
    drive_cycle();
    arb_en = 1'b1;
    sample();
    sample();
    chk("t5_grant0", 32'(rd_vec), 32'h1);
    sample();
    chk("t5_grant1", 32'(rd_vec), 32'h2);
    drive_cycle();
    arb_en = 1'b0;
    sample();
    chk("t5_c3_rd_en", 32'(rd_vec), 32'd0);
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("t5_drain_rd_en", 32'(rd_vec), 32'd0);
      chk("t5_drain_busy", 32'(busy), 32'd1);
      chk("t5_drain_valid", 32'(out_valid), 32'd1);
    end
    drive_cycle();
    out_ready = 1'b1;
    sample();
    chk("t5_pop0_valid", 32'(out_valid), 32'd1);
    sample();
    chk("t5_pop1_valid", 32'(out_valid), 32'd1);
    sample();
    chk("t5_empty_valid", 32'(out_valid), 32'd0);
    chk("t5_busy_hold", 32'(busy), 32'd1);
    sample();
    chk("t5_busy_fall", 32'(busy), 32'd0);
    chk("t5_sb_empty", 32'(sb.size()), 32'd0);
    do_reset();

    // reset with two buffered words
    drive_cycle();
    arb_en = 1'b1;
    for (int i = 0; i < 4; i++) sample();
    drive_cycle();
    rst = 1'b1;
    sample();
    chk("t6_pre_valid", 32'(out_valid), 32'd1);
    chk("t6_rst_rd_en", 32'(rd_vec), 32'd0);
    drive_cycle();
    sb.delete();
    rst = 1'b0;
    sample();
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_rd_en", 32'(rd_vec), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    sample();
    chk("t6_first_grant", 32'(rd_vec), 32'h1);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
